mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences and shares the single byte-addressable data memory (`mem`, 256 bytes) between the instruction-fetch unit (port IF) and the load/store unit (port LS) of the multi-cycle core.
- Accepts one request at a time and drives the memory's address, data_in, wr_en, mem_size and sz_ex.
- Captures data_out and returns a registered response with an error flag for illegal accesses.

Parameters:
- BUS_WIDTH, 32, data/address width.
- MEM_BYTES, 256, memory size in bytes; bounds check limit.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch byte address; always a WORD, zero-extended access
- if_gnt  out  1  one-cycle accept pulse
- if_rsp_valid  out  1  one-cycle response pulse
- if_rdata  out  32  fetched word
- if_err  out  1  fetch was misaligned or out of range; valid with if_rsp_valid
- ls_req  in  1  load/store request; held until ls_gnt
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, right-aligned
- ls_wr  in  1  1 = store, 0 = load
- ls_size  in  2  00 BYTE, 01 HALF_WORD, 10 WORD, 11 illegal
- ls_sz_ex  in  1  1 = sign-extend load
- ls_gnt  out  1  one-cycle accept pulse
- ls_rsp_valid  out  1  one-cycle response pulse
- ls_rdata  out  32  load data; 0 for stores
- ls_err  out  1  illegal access; valid with ls_rsp_valid
- mem_address  out  32  to mem.address
- mem_data_in  out  32  to mem.data_in
- mem_wr_en  out  1  to mem.wr_en
- mem_size  out  2  to mem.mem_size
- mem_sz_ex  out  1  to mem.sz_ex
- mem_data_out  in  32  from mem.data_out (combinational read)
- busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is pending, grant one (gnt pulse this cycle), latch its fields into a request register, go to ACCESS.
- ACCESS: registered mem_* outputs present the latched request for exactly one cycle.
  - mem_wr_en = 1 only for a legal store.
  - At the end of ACCESS, capture mem_data_out into the response register (loads and fetches) and go to RESP.
- RESP: the owning port's rsp_valid = 1 for one cycle with rdata/err; go to IDLE. No back-to-back grant from RESP.
- Fixed latency: gnt in cycle N, mem access in cycle N+1, rsp_valid in cycle N+2. One transaction per 3 cycles maximum.
- Arbitration: if only one port requests, grant it. If both request, grant the port not granted last (round-robin).
- last_grant resets to LS, so IF wins the first conflict.
- A request arriving while busy is not granted; the requester must hold req, fields stable.
- Fetch is forced to mem_size = WORD, mem_sz_ex = 0, mem_wr_en = 0.
- Legality check, decided at grant:
  - size 11 is illegal.
  - WORD requires addr[1:0] == 0; HALF_WORD requires addr[0] == 0.
  - addr + access bytes > MEM_BYTES is illegal; the comparison is done in 33 bits so no wrap-around.
- Illegal access: still passes through ACCESS (same latency), but mem_wr_en stays 0, rdata = 0, err = 1. Memory contents are unchanged.
- Store response: rdata = 0, err = 0.
- Outside ACCESS: mem_wr_en = 0. mem_address, mem_data_in, mem_size and mem_sz_ex hold their last values.
- Reset values: all gnt/rsp_valid/err/busy = 0; rdata = 0; mem_address = 0, mem_data_in = 0, mem_wr_en = 0, mem_size = WORD, mem_sz_ex = 0; state = IDLE.
- Reset mid-transaction: abort immediately with the reset values above. The in-flight request is dropped with no rsp_valid; a store in ACCESS may or may not have committed.
- Simultaneous req deassert on the gnt cycle is legal; the request is already latched.

Decomposition:
- Shared package/header mem_defs: BUS_WIDTH, MEM_VECTOR_SIZE, size codes WORD / HALF_WORD / BYTE, FSM state encodings, port IDs (PORT_IF, PORT_LS).
- One natural sub-module: mem_access_check (combinational). Inputs addr and size; output illegal. Reused by the LSU for early trap detection.

Test Plan:
- Reset, then LS store WORD 0x00FFFFFF @ 8; then LS load WORD @ 8 -> ls_gnt in cycle N, mem_wr_en = 1 only in N+1, ls_rsp_valid in N+2; load returns 0x00FFFFFF, err = 0.
- Store WORD 0x000000FF @ 0; load BYTE @ 0 with sz_ex = 1 -> rdata 0xFFFFFFFF; same load with sz_ex = 0 -> 0x000000FF.
- if_req and ls_req asserted together, held continuously -> grants alternate IF, LS, IF, LS with 3-cycle spacing; each rsp_valid goes only to the granted port.
- LS store HALF_WORD @ 3, and WORD @ 254 -> ls_err = 1, mem_wr_en never 1; reading @ 0 afterwards shows memory unchanged.
- LS load with size 11 -> err = 1, rdata = 0; fetch @ 0x102 -> if_err = 1.
- rst low during ACCESS of a load -> all outputs at reset values asynchronously, no rsp_valid; after release, a new if_req is granted from IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the data-memory arbiter and its access checker:
//   bus/memory sizing, mem_size codes, arbiter FSM encodings, requester IDs,
//   the latched-request record and a helper that maps a size code to bytes.
package mem_arbiter_pkg;

  localparam int MEM_BUS_WIDTH   = 32;
  localparam int MEM_VECTOR_SIZE = 256;

  // mem_size encodings shared with the memory and the LSU
  localparam logic [1:0] BYTE         = 2'b00;
  localparam logic [1:0] HALF_WORD    = 2'b01;
  localparam logic [1:0] WORD         = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Arbiter FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  // Requester IDs
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Per-transaction attributes kept from grant until the response
  typedef struct packed {
    logic port;     // owning requester
    logic wr;       // store (only ever set for LS)
    logic illegal;  // access check failed at grant
  } req_info_t;

  // Number of bytes touched by an access of the given size code.
  // The illegal code reports 4; it is rejected separately.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      BYTE:      access_bytes = 3'd1;
      HALF_WORD: access_bytes = 3'd2;
      default:   access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_check.sv
// mem_access_check
//   Combinational legality check for one memory access. Also usable by the
//   LSU for early trap detection.
//   addr    in  ADDR_W  byte address
//   size    in  2       mem_size code
//   illegal out 1       illegal size code, misaligned, or runs past MEM_BYTES
module mem_access_check
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = MEM_BUS_WIDTH,
  parameter int MEM_BYTES = MEM_VECTOR_SIZE
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  output logic              illegal
);

  // One extra bit so addr + bytes cannot wrap back into range
  localparam int XW = ADDR_W + 1;

  logic [ADDR_W:0] end_addr;
  logic            misaligned;

  always_comb begin
    end_addr   = {1'b0, addr} + XW'(access_bytes(size));
    misaligned = 1'b0;
    case (size)
      WORD:      misaligned = (addr[1:0] != 2'b00);
      HALF_WORD: misaligned = addr[0];
      default:   misaligned = 1'b0;
    endcase
    illegal = (size == SIZE_ILLEGAL) || misaligned || (end_addr > XW'(MEM_BYTES));
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single byte-addressable data memory between instruction fetch
//   (IF) and load/store (LS). One transaction at a time with fixed latency:
//   gnt in cycle N, memory access in N+1, registered response in N+2.
//   Round-robin on conflict; IF wins the first conflict after reset.
//
//   clk, rst             clock; asynchronous active-low reset
//   if_req/if_addr       fetch request (always WORD, zero-extended)
//   if_gnt               accept pulse (combinational, IDLE only)
//   if_rsp_valid/rdata/err  registered fetch response
//   ls_req/addr/wdata/wr/size/sz_ex  load/store request
//   ls_gnt               accept pulse
//   ls_rsp_valid/rdata/err  registered load/store response
//   mem_address/data_in/wr_en/size/sz_ex  registered memory controls
//   mem_data_out         combinational read data from the memory
//   busy                 FSM not in IDLE
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | waiting; grants a pending request and latches it
//   ST_ACCESS | mem_* present the latched request; read data captured
//   ST_RESP   | owning port's rsp_valid high for one cycle; no grant here
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH = MEM_BUS_WIDTH,
  parameter int MEM_BYTES = MEM_VECTOR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [BUS_WIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rsp_valid,
  output logic [BUS_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 ls_req,
  input  logic [BUS_WIDTH-1:0] ls_addr,
  input  logic [BUS_WIDTH-1:0] ls_wdata,
  input  logic                 ls_wr,
  input  logic [1:0]           ls_size,
  input  logic                 ls_sz_ex,
  output logic                 ls_gnt,
  output logic                 ls_rsp_valid,
  output logic [BUS_WIDTH-1:0] ls_rdata,
  output logic                 ls_err,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_data_in,
  output logic                 mem_wr_en,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_data_out,
  output logic                 busy
);

  logic [1:0]           state;
  logic                 last_grant;
  req_info_t            req_q;

  logic                 grant_any;
  logic                 sel_port;
  logic [BUS_WIDTH-1:0] sel_addr;
  logic [1:0]           sel_size;
  logic                 sel_illegal;
  logic                 sel_store;

  always_comb begin
    grant_any = (state == ST_IDLE) && (if_req || ls_req);
    if (if_req && ls_req) begin
      sel_port = (last_grant == PORT_LS) ? PORT_IF : PORT_LS;
    end else if (if_req) begin
      sel_port = PORT_IF;
    end else begin
      sel_port = PORT_LS;
    end
    sel_addr  = (sel_port == PORT_IF) ? if_addr : ls_addr;
    sel_size  = (sel_port == PORT_IF) ? WORD : ls_size;
    sel_store = (sel_port == PORT_LS) && ls_wr;
  end

  mem_access_check #(
    .ADDR_W   (BUS_WIDTH),
    .MEM_BYTES(MEM_BYTES)
  ) u_access_check (
    .addr   (sel_addr),
    .size   (sel_size),
    .illegal(sel_illegal)
  );

  // Gated by rst so no accept pulse can escape while reset is asserted
  assign if_gnt = rst && grant_any && (sel_port == PORT_IF);
  assign ls_gnt = rst && grant_any && (sel_port == PORT_LS);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_grant   <= PORT_LS;
      req_q        <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_wr_en    <= 1'b0;
      mem_size     <= WORD;
      mem_sz_ex    <= 1'b0;
      if_rsp_valid <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_rdata     <= '0;
      ls_err       <= 1'b0;
    end else begin
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      mem_wr_en    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state         <= ST_ACCESS;
            last_grant    <= sel_port;
            req_q.port    <= sel_port;
            req_q.wr      <= sel_store;
            req_q.illegal <= sel_illegal;
            mem_address   <= sel_addr;
            mem_wr_en     <= sel_store && !sel_illegal;
            if (sel_port == PORT_IF) begin
              // data_in is irrelevant for a fetch, so it keeps its last value
              mem_size  <= WORD;
              mem_sz_ex <= 1'b0;
            end else begin
              mem_data_in <= ls_wdata;
              mem_size    <= ls_size;
              mem_sz_ex   <= ls_sz_ex;
            end
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          if (req_q.port == PORT_IF) begin
            if_rsp_valid <= 1'b1;
            if_rdata     <= req_q.illegal ? '0 : mem_data_out;
            if_err       <= req_q.illegal;
          end else begin
            ls_rsp_valid <= 1'b1;
            ls_rdata     <= (req_q.illegal || req_q.wr) ? '0 : mem_data_out;
            ls_err       <= req_q.illegal;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
